// File: rtl/store_buffer.sv
// store_buffer: FIFO store queue with load forwarding in front of dm (st_* in, ld_* lookup, dm_* port, count/empty/full status)
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int STARVE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic [31:0]              ld_data,
  output logic                     ld_stall,
  output logic [31:0]              dm_addr,
  output logic                     dm_wr,
  output logic [31:0]              dm_wdata,
  input  logic [31:0]              dm_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE + 1);
  logic [31:0] e_addr [DEPTH];
  logic [31:0] e_data [DEPTH];
  logic [AW-1:0] head, tail;
  logic [SW-1:0] starve_cnt;
  logic push, drain, force_drain, hit;
  logic [31:0] fwd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign st_ready = !full;
  assign force_drain = starve_cnt == SW'(STARVE);
  assign push = st_valid && !full;
  assign drain = !empty && (!ld_valid || force_drain);
  assign ld_stall = ld_valid && force_drain;
  assign dm_wr = drain;
  assign dm_addr = drain ? e_addr[head] : ld_valid ? ld_addr : '0;
  assign dm_wdata = drain ? e_data[head] : '0;
  assign ld_data = hit ? fwd : dm_rdata;
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count && e_addr[head + AW'(i)] == ld_addr) begin
        hit = 1'b1;
        fwd = e_data[head + AW'(i)];
      end
  end
  always_ff @(posedge clk)
    if (push) begin
      e_addr[tail] <= st_addr;
      e_data[tail] <= st_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      starve_cnt <= '0;
    end else begin
      head <= head + AW'(drain);
      tail <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(drain);
      starve_cnt <= (drain || !full) ? '0 : (ld_valid && !force_drain) ? starve_cnt + 1'b1 : starve_cnt;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-coalescing-free store buffer that is the front end of the data memory `dm` in the MEM stage. It accepts stores from the EX/MEM pipeline register, queues them in a small FIFO and drains them into `dm` on cycles when no load needs the memory port. Loads look up the buffer and receive the youngest matching queued store data (store-to-load forwarding); otherwise they receive `dm` read data. The block owns `dm`'s address/write port; `dm.rd` is tied 0 at the top level.

## Interface
- DEPTH, 4, number of entries (power of two, ≥2)
- STARVE, 4, consecutive drain-blocked cycles while full before drain takes priority over loads

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request this cycle
- st_addr  in  32  store word address
- st_data  in  32  store data
- st_ready  out  1  buffer can accept a store (= !full)
- ld_valid  in  1  load request this cycle
- ld_addr  in  32  load word address
- ld_data  out  32  load result (combinational)
- ld_stall  out  1  load not serviced this cycle; MEM stage must hold
- dm_addr  out  32  to `dm.addr`
- dm_wr  out  1  to `dm.wr`
- dm_wdata  out  32  to `dm.wdata`
- dm_rdata  in  32  from `dm.rdata`
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage: DEPTH entries {addr[31:0], data[31:0]}, head (oldest) and tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH; count register separate from pointers.
- Push: st_valid && st_ready → write entry at tail, tail+1. st_valid while full is ignored (upstream must hold until st_ready).
- Drain request: !empty. Drain granted when (!ld_valid) or force_drain. Granted drain: dm_wr=1, dm_addr=head.addr, dm_wdata=head.data; head+1 at the edge (dm writes the same edge).
- Load service: ld_valid && !force_drain → dm_addr=ld_addr, dm_wr=0, ld_stall=0. ld_valid && force_drain → ld_stall=1, ld_data don't-care.
- Forwarding: compare ld_addr (all 32 bits) against every valid entry; on one or more hits ld_data = data of youngest hit (closest to tail); no hit → ld_data = dm_rdata. A store pushed in the same cycle is not forwarded.
- Idle (no load, empty): dm_wr=0, dm_addr=0, dm_wdata=0.
- Starvation counter starve_cnt: increments each cycle full && ld_valid && drain not granted; clears on any granted drain or when !full. force_drain = (starve_cnt == STARVE). Saturates at STARVE.
- Duplicate addresses are queued separately; drain order is strict FIFO, so final memory value is the youngest store.
- Push and drain in the same cycle: both occur, count unchanged. Push when full with drain same cycle: rejected (st_ready is registered-state based, no push-through).

## Timing
- Reset (async assert, sync-safe deassert): head=tail=0, count=0, starve_cnt=0 → empty=1, full=0, st_ready=1, dm_wr=0, ld_stall=0, dm_addr=0, dm_wdata=0, ld_data=dm_rdata. Entry contents undefined; reset mid-operation discards all queued stores, no further dm_wr.
- Store visible to forwarding the cycle after push; written to `dm` at the earliest edge with no load, minimum 1 cycle after push.
- ld_data, ld_stall, dm_* are combinational from current state and inputs; zero-cycle load latency (single-cycle `dm` read).
- Worst-case load wait: STARVE cycles blocked-while-full, then one forced drain cycle with ld_stall=1.

## Test plan
- Reset then 3 stores (A=0x10/0x11, 0x14/0x22, 0x18/0x33) with ld_valid=0 → count rises to 1,1,1 (push+drain each cycle after first), dm_wr each cycle, mem[0x10]=0x11, 0x14=0x22, 0x18=0x33, ends empty.
- Hold ld_valid=1 (addr 0x40), push 4 stores → full=1, st_ready=0, no dm_wr for 4 cycles, then ld_stall=1 with dm_wr=1 of oldest; count 4→3, starve_cnt cleared.
- Push 0x20/0xAA then 0x20/0xBB while loading; load 0x20 → ld_data=0xBB; after drain, load 0x20 from `dm` → 0xBB.
- Load 0x30 (no entry) with dm mem[0x30]=0x5 → ld_data=0x5, ld_stall=0, dm_addr=0x30.
- Fill to 2 entries, assert rst_n=0 mid-cycle → empty=1, count=0, dm_wr=0 immediately; no memory writes after release.
- Tail/head wrap: 10 push/drain cycles at DEPTH=4 → FIFO order preserved across wrap, count never exceeds 4.
